// File: rtl/life_grid_seq_if.sv
// Host-side bus for life_grid_seq.
//   load_en/load_row/load_data : write one row of the committed grid (idle only)
//   start/gens                 : request a run of gens generations (idle only)
//   abort                      : stop a run in progress
//   rd_row/rd_data             : combinational read of a committed grid row
//   busy/done                  : run in progress / one-cycle end-of-run pulse
//   gen_count                  : committed generations since reset (wraps)
// The slave modport is the sequencer side; master is the host side.
interface life_grid_seq_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned H  = 8,
  parameter int unsigned GW = 16
) ();
  logic                 load_en;
  logic [$clog2(H)-1:0] load_row;
  logic [W-1:0]         load_data;
  logic                 start;
  logic [GW-1:0]        gens;
  logic                 abort;
  logic [$clog2(H)-1:0] rd_row;
  logic [W-1:0]         rd_data;
  logic                 busy;
  logic                 done;
  logic [GW-1:0]        gen_count;

  modport slave (
    input  load_en, load_row, load_data, start, gens, abort, rd_row,
    output rd_data, busy, done, gen_count
  );

  modport master (
    output load_en, load_row, load_data, start, gens, abort, rd_row,
    input  rd_data, busy, done, gen_count
  );
endinterface

// File: rtl/life_grid_seq.sv
// Toroidal Game-of-Life sequencer.
// One rule evaluator is swept over all W*H cells (one cell per clock) writing a
// shadow grid; the shadow is then committed to the visible grid in one cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears both grids and all counters)
//   bus   : life_grid_seq_if.slave host bus (load, start/gens, abort, read,
//           busy/done handshake, gen_count)
module life_grid_seq #(
  parameter int unsigned W  = 8,
  parameter int unsigned H  = 8,
  parameter int unsigned GW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  life_grid_seq_if.slave       bus
);

  localparam int unsigned RW = $clog2(H);
  localparam int unsigned CW = $clog2(W);
  localparam logic [RW-1:0] RowMax = RW'(H - 1);
  localparam logic [CW-1:0] ColMax = CW'(W - 1);

  typedef enum logic [1:0] {StIdle, StEval, StCommit, StFin} state_e;

  state_e                 state_q, state_d;
  logic [H-1:0][W-1:0]    cur_q, cur_d;
  logic [H-1:0][W-1:0]    shd_q, shd_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic [GW-1:0]          rem_q, rem_d;
  logic [GW-1:0]          gcnt_q, gcnt_d;

  logic [RW-1:0]          row_up, row_dn;
  logic [CW-1:0]          col_lf, col_rt;
  logic [3:0]             nbr_cnt;
  logic                   cell_next;

  // Neighbour coordinates wrap around the torus edges.
  always_comb begin
    row_up = (row_q == '0)     ? RowMax : row_q - RW'(1);
    row_dn = (row_q == RowMax) ? '0     : row_q + RW'(1);
    col_lf = (col_q == '0)     ? ColMax : col_q - CW'(1);
    col_rt = (col_q == ColMax) ? '0     : col_q + CW'(1);

    nbr_cnt = 4'(cur_q[row_up][col_lf]) + 4'(cur_q[row_up][col_q]) +
              4'(cur_q[row_up][col_rt]) + 4'(cur_q[row_q][col_lf])  +
              4'(cur_q[row_q][col_rt])  + 4'(cur_q[row_dn][col_lf]) +
              4'(cur_q[row_dn][col_q])  + 4'(cur_q[row_dn][col_rt]);

    cell_next = (cur_q[row_q][col_q] & (nbr_cnt == 4'd2)) | (nbr_cnt == 4'd3);
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    shd_d   = shd_q;
    row_d   = row_q;
    col_d   = col_q;
    rem_d   = rem_q;
    gcnt_d  = gcnt_q;

    unique case (state_q)
      StIdle: begin
        // A load in the same cycle as start takes priority; start is dropped.
        if (bus.load_en) begin
          cur_d[bus.load_row] = bus.load_data;
        end else if (bus.start) begin
          rem_d   = bus.gens;
          state_d = (bus.gens != '0) ? StEval : StFin;
        end
      end

      StEval: begin
        if (bus.abort) begin
          row_d   = '0;
          col_d   = '0;
          state_d = StFin;
        end else begin
          shd_d[row_q][col_q] = cell_next;
          if (col_q == ColMax) begin
            col_d = '0;
            if (row_q == RowMax) begin
              row_d   = '0;
              state_d = StCommit;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      StCommit: begin
        // The commit always completes; abort only cuts off further generations.
        cur_d   = shd_q;
        gcnt_d  = gcnt_q + GW'(1);
        rem_d   = rem_q - GW'(1);
        state_d = (bus.abort || rem_q == GW'(1)) ? StFin : StEval;
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      shd_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rem_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      shd_q   <= shd_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rem_q   <= rem_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign bus.rd_data   = cur_q[bus.rd_row];
  assign bus.busy      = (state_q == StEval) || (state_q == StCommit);
  assign bus.done      = (state_q == StFin);
  assign bus.gen_count = gcnt_q;

endmodule

// File: tb/tb_life_grid_seq.sv
module tb_life_grid_seq;
  localparam int W     = 8;
  localparam int H     = 8;
  localparam int GW    = 16;
  localparam int RW    = $clog2(H);
  localparam int CELLS = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  life_grid_seq_if #(.W(W), .H(H), .GW(GW)) bus ();

  life_grid_seq #(.W(W), .H(H), .GW(GW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of rows plus a generation counter.
  logic [W-1:0] mg[H];
  int unsigned  mgc;
  logic [W-1:0] got_g[H];

  // Results of the most recent run.
  int   done_cyc;
  int   busy_hi;
  logic busy_at_done;
  logic done_after;

  task automatic model_step();
    logic [W-1:0] nx[H];
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              cnt += int'(mg[(r + dr + H) % H][(c + dc + W) % W]);
        nx[r][c] = (cnt == 3) || (mg[r][c] && cnt == 2);
      end
    end
    mg = nx;
    mgc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_row  = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.gens      = '0;
    bus.abort     = 1'b0;
    bus.rd_row    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < H; r++) mg[r] = '0;
    mgc = 0;
  endtask

  task automatic load(input int r, input logic [W-1:0] d);
    @(negedge clk);
    bus.load_en   = 1'b1;
    bus.load_row  = RW'(r);
    bus.load_data = d;
    @(negedge clk);
    bus.load_en = 1'b0;
    mg[r] = d;
  endtask

  task automatic read_grid();
    for (int r = 0; r < H; r++) begin
      @(negedge clk);
      bus.rd_row = RW'(r);
      #1;
      got_g[r] = bus.rd_data;
    end
  endtask

  // Cycle 0 is the cycle whose closing edge samples start.
  task automatic run(input int n, input int abort_at, input bit disturb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.gens  = GW'(n);
    done_cyc  = -1;
    busy_hi   = 0;
    busy_at_done = 1'b1;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      bus.start   = 1'b0;
      bus.load_en = 1'b0;
      bus.abort   = 1'b0;
      if (bus.busy) busy_hi++;
      if (bus.done) begin
        done_cyc     = c;
        busy_at_done = bus.busy;
        break;
      end
      if (c == abort_at) bus.abort = 1'b1;
      if (disturb && (c == 5 || c == CELLS + 1 || c == CELLS + 9)) begin
        bus.load_en   = 1'b1;
        bus.load_row  = '0;
        bus.load_data = '1;
        bus.start     = 1'b1;
        bus.gens      = GW'(7);
      end
    end
    bus.gens = '0;
    @(negedge clk);
    done_after = bus.done;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.gen_count !== '0) begin errors++; $display("FAIL reset_gen_count got %0d exp 0", bus.gen_count); end
    read_grid();
    for (int r = 0; r < H; r++) begin
      checks++; if (got_g[r] !== '0) begin errors++; $display("FAIL reset_row%0d got %h exp 00", r, got_g[r]); end
    end
  endtask

  task automatic test_blinker();
    logic [W-1:0] exp_r;
    // One generation: horizontal -> vertical.
    do_reset();
    load(3, 8'h1C);
    run(1, -1, 1'b0);
    checks++; if (done_cyc !== 66) begin errors++; $display("FAIL blinker1_done_cycle got %0d exp 66", done_cyc); end
    checks++; if (busy_hi !== CELLS + 1) begin errors++; $display("FAIL blinker1_busy_cycles got %0d exp %0d", busy_hi, CELLS + 1); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL blinker1_busy_in_fin got %b exp 0", busy_at_done); end
    checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL blinker1_done_pulse got %b exp 0", done_after); end
    read_grid();
    for (int r = 0; r < H; r++) begin
      exp_r = (r >= 2 && r <= 4) ? 8'h08 : 8'h00;
      checks++; if (got_g[r] !== exp_r) begin errors++; $display("FAIL blinker1_row%0d got %h exp %h", r, got_g[r], exp_r); end
    end
    checks++; if (bus.gen_count !== GW'(1)) begin errors++; $display("FAIL blinker1_gen_count got %0d exp 1", bus.gen_count); end
    // Two generations: back to horizontal.
    do_reset();
    load(3, 8'h1C);
    run(2, -1, 1'b0);
    checks++; if (done_cyc !== 131) begin errors++; $display("FAIL blinker2_done_cycle got %0d exp 131", done_cyc); end
    read_grid();
    for (int r = 0; r < H; r++) begin
      exp_r = (r == 3) ? 8'h1C : 8'h00;
      checks++; if (got_g[r] !== exp_r) begin errors++; $display("FAIL blinker2_row%0d got %h exp %h", r, got_g[r], exp_r); end
    end
    checks++; if (bus.gen_count !== GW'(2)) begin errors++; $display("FAIL blinker2_gen_count got %0d exp 2", bus.gen_count); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp_r;
    do_reset();
    load(0, 8'h07);
    run(1, -1, 1'b0);
    read_grid();
    for (int r = 0; r < H; r++) begin
      exp_r = (r == 7 || r == 0 || r == 1) ? 8'h02 : 8'h00;
      checks++; if (got_g[r] !== exp_r) begin errors++; $display("FAIL wrap_row%0d got %h exp %h", r, got_g[r], exp_r); end
    end
  endtask

  task automatic test_still_zero();
    logic [W-1:0] exp_r;
    do_reset();
    load(0, 8'h81);
    load(7, 8'h81);
    run(3, -1, 1'b0);
    checks++; if (done_cyc !== 3 * (CELLS + 1) + 1) begin errors++; $display("FAIL still_done_cycle got %0d exp %0d", done_cyc, 3 * (CELLS + 1) + 1); end
    read_grid();
    for (int r = 0; r < H; r++) begin
      exp_r = (r == 0 || r == 7) ? 8'h81 : 8'h00;
      checks++; if (got_g[r] !== exp_r) begin errors++; $display("FAIL still_row%0d got %h exp %h", r, got_g[r], exp_r); end
    end
    run(0, -1, 1'b0);
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL zero_gens_done_cycle got %0d exp 1", done_cyc); end
    checks++; if (busy_hi !== 0) begin errors++; $display("FAIL zero_gens_busy got %0d exp 0", busy_hi); end
    checks++; if (bus.gen_count !== GW'(3)) begin errors++; $display("FAIL zero_gens_gen_count got %0d exp 3", bus.gen_count); end
    read_grid();
    for (int r = 0; r < H; r++) begin
      exp_r = (r == 0 || r == 7) ? 8'h81 : 8'h00;
      checks++; if (got_g[r] !== exp_r) begin errors++; $display("FAIL zero_gens_row%0d got %h exp %h", r, got_g[r], exp_r); end
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] exp_r;
    do_reset();
    load(3, 8'h1C);
    run(5, 100, 1'b0);
    checks++; if (done_cyc !== 101) begin errors++; $display("FAIL abort_done_cycle got %0d exp 101", done_cyc); end
    checks++; if (bus.gen_count !== GW'(1)) begin errors++; $display("FAIL abort_gen_count got %0d exp 1", bus.gen_count); end
    read_grid();
    for (int r = 0; r < H; r++) begin
      exp_r = (r >= 2 && r <= 4) ? 8'h08 : 8'h00;
      checks++; if (got_g[r] !== exp_r) begin errors++; $display("FAIL abort_row%0d got %h exp %h", r, got_g[r], exp_r); end
    end
    // Abort landing on the commit cycle still commits that generation.
    run(3, CELLS + 1, 1'b0);
    checks++; if (done_cyc !== CELLS + 2) begin errors++; $display("FAIL abort_commit_done_cycle got %0d exp %0d", done_cyc, CELLS + 2); end
    checks++; if (bus.gen_count !== GW'(2)) begin errors++; $display("FAIL abort_commit_gen_count got %0d exp 2", bus.gen_count); end
    read_grid();
    checks++; if (got_g[3] !== 8'h1C) begin errors++; $display("FAIL abort_commit_row3 got %h exp 1c", got_g[3]); end
  endtask

  task automatic test_ignored();
    logic [W-1:0] exp_r;
    do_reset();
    load(3, 8'h1C);
    run(2, -1, 1'b1);
    checks++; if (done_cyc !== 131) begin errors++; $display("FAIL ignored_done_cycle got %0d exp 131", done_cyc); end
    checks++; if (bus.gen_count !== GW'(2)) begin errors++; $display("FAIL ignored_gen_count got %0d exp 2", bus.gen_count); end
    read_grid();
    for (int r = 0; r < H; r++) begin
      exp_r = (r == 3) ? 8'h1C : 8'h00;
      checks++; if (got_g[r] !== exp_r) begin errors++; $display("FAIL ignored_row%0d got %h exp %h", r, got_g[r], exp_r); end
    end
    // Load and start together in idle, with a stray abort: only the load acts.
    @(negedge clk);
    bus.load_en   = 1'b1;
    bus.load_row  = RW'(5);
    bus.load_data = 8'hA5;
    bus.start     = 1'b1;
    bus.gens      = GW'(1);
    bus.abort     = 1'b1;
    @(negedge clk);
    bus.load_en = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.gens    = '0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL load_start_idle c%0d got busy=%b done=%b exp 0 0", i, bus.busy, bus.done); end
      @(negedge clk);
    end
    bus.rd_row = RW'(5);
    #1;
    checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL load_start_row5 got %h exp a5", bus.rd_data); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int n;
      int a;
      do_reset();
      for (int r = 0; r < H; r++) load(r, W'($urandom));
      n = $urandom_range(1, 3);
      a = (it >= 2) ? $urandom_range(1, n * (CELLS + 1)) : -1;
      run(n, a, it[0]);
      if (a < 0) begin
        repeat (n) model_step();
        checks++; if (done_cyc !== n * (CELLS + 1) + 1) begin errors++; $display("FAIL rand%0d_done_cycle got %0d exp %0d", it, done_cyc, n * (CELLS + 1) + 1); end
      end else begin
        repeat (a / (CELLS + 1)) model_step();
        checks++; if (done_cyc !== a + 1) begin errors++; $display("FAIL rand%0d_abort_done_cycle got %0d exp %0d", it, done_cyc, a + 1); end
      end
      checks++; if (bus.gen_count !== GW'(mgc)) begin errors++; $display("FAIL rand%0d_gen_count got %0d exp %0d", it, bus.gen_count, mgc); end
      read_grid();
      for (int r = 0; r < H; r++) begin
        checks++; if (got_g[r] !== mg[r]) begin errors++; $display("FAIL rand%0d_row%0d got %h exp %h", it, r, got_g[r], mg[r]); end
      end
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    load(3, 8'h1C);
    @(negedge clk);
    bus.start = 1'b1;
    bus.gens  = GW'(3);
    @(negedge clk);
    bus.start = 1'b0;
    bus.gens  = '0;
    repeat (100) @(negedge clk);
    bus.rd_row = RW'(2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.gen_count !== '0) begin errors++; $display("FAIL midreset_gen_count got %0d exp 0", bus.gen_count); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL midreset_row2 got %h exp 00", bus.rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset_idle got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
  endtask

  initial begin
    bus.load_en   = 1'b0;
    bus.load_row  = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.gens      = '0;
    bus.abort     = 1'b0;
    bus.rd_row    = '0;
    test_reset();
    test_blinker();
    test_wrap();
    test_still_zero();
    test_abort();
    test_ignored();
    test_random();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/life_grid_seq.md
Name: life_grid_seq

Overview:
- Sequencer that runs generations of a toroidal Game-of-Life grid stored in on-chip registers.
- Time-multiplexes a single per-cell rule evaluator over all W*H cells, one cell per clock, into a shadow grid, then commits the shadow grid atomically.
- Host side loads/reads rows and requests N generations with a start/busy/done handshake.

Parameters:
- W, 8, grid width in cells (columns); 3 to 32.
- H, 8, grid height in cells (rows); 3 to 32.
- GW, 16, width of generation request and generation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_en  in  1  write load_data into current-grid row load_row (IDLE only).
- load_row  in  clog2(H)  row index for load.
- load_data  in  W  row contents; bit c = column c, 1 = alive.
- start  in  1  request to run gens generations (IDLE only).
- gens  in  GW  number of generations, sampled with start.
- abort  in  1  stop run, discard shadow grid.
- rd_row  in  clog2(H)  row index for read.
- rd_data  out  W  current (committed) grid row rd_row, combinational.
- busy  out  1  high from cycle after start accepted until done.
- done  out  1  one-cycle pulse at end of run or abort.
- gen_count  out  GW  total committed generations since reset, wraps at 2^GW.

Behaviour:
- Reset (async, rst_n=0): both grids all-zero, state IDLE, busy=0, done=0, gen_count=0, remaining=0, cell index=0.
- States: IDLE, EVAL, COMMIT, FIN.
- IDLE:
  - load_en writes current grid row load_row.
  - start with load_en=0 latches remaining=gens; next state EVAL if gens!=0, else FIN.
  - load_en and start in the same cycle: load wins, start ignored.
- EVAL: each cycle evaluates cell idx (row = idx/W, col = idx%W), writes the result to shadow[row][col], and increments idx.
  - Neighbours: the 8 surrounding cells of the current grid with modulo wrap (row-1 of row 0 = row H-1; col-1 of col 0 = col W-1, etc.).
  - Count is a 4-bit sum of the 8 neighbours.
  - Rule: next = (self & count==2) | (count==3).
  - After idx = W*H-1, go to COMMIT and reset idx to 0.
- COMMIT (1 cycle): current <= shadow; gen_count += 1; remaining -= 1. Next state EVAL if remaining != 0 after decrement, else FIN.
- FIN (1 cycle): done=1, busy=0 next; return to IDLE.
- Timing:
  - Each generation costs exactly W*H+1 cycles.
  - With start sampled at cycle 0 and gens=N>0, done is high in cycle N*(W*H+1)+1.
  - With gens=0, done is high in cycle 1 and the grid is unchanged.
- busy is high in EVAL and COMMIT. It is low in IDLE and FIN.
- Ignored inputs: load_en and start while not IDLE; abort in IDLE or FIN.
- abort in EVAL:
  - Go to FIN, clear idx, shadow discarded. Current grid and gen_count hold their last committed values.
- abort in COMMIT:
  - The commit completes (grid and gen_count update), then go to FIN.
- rd_data always reflects the committed grid and never shows partial evaluation.
- Mid-run reset: immediate return to the reset values above; the grid is cleared.

Test Plan:
- Blinker, 8x8: load row 3 = 0x1C, start gens=1 -> done at cycle 66; rows 2,3,4 = 0x08, all other rows 0; gen_count=1.
- Blinker period: same load, gens=2 -> done at cycle 131; row 3 = 0x1C, others 0; gen_count=2.
- Toroidal wrap: load row 0 = 0x07 only, gens=1 -> rows 7,0,1 = 0x02; others 0.
- Still life plus zero gens: 2x2 block at rows 0,7 cols 0,7 (rows 0 and 7 = 0x81), gens=3 -> unchanged. Then start gens=0 -> done at cycle 1, busy never high, gen_count unchanged.
- Abort: blinker loaded, gens=5, abort at cycle 100 (during generation 2 EVAL) -> done pulse in cycle 101; grid = vertical blinker (one commit); gen_count=1.
- Ignored inputs while busy: during a run, pulse load_en (row 0 = 0xFF) and start -> no grid or gens effect; result identical to the undisturbed run. Simultaneous load_en+start in IDLE -> load applied, busy stays 0.
